// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared ULPI encodings, register map, reset defaults and PHY responder states.
package ulpi_pkg;

    localparam logic [1:0] CMD_TX   = 2'b01;
    localparam logic [1:0] CMD_REGW = 2'b10;
    localparam logic [1:0] CMD_REGR = 2'b11;

    localparam logic [5:0] A_VID  = 6'h00;
    localparam logic [5:0] A_PID  = 6'h02;
    localparam logic [5:0] A_FUNC = 6'h04;
    localparam logic [5:0] A_IFC  = 6'h07;
    localparam logic [5:0] A_OTG  = 6'h0A;

    localparam logic [7:0] FUNC_RST = 8'h41;
    localparam logic [7:0] IFC_RST  = 8'h00;
    localparam logic [7:0] OTG_RST  = 8'h06;
    localparam int         FUNC_RESET_BIT = 5;

    localparam logic [1:0] EVT_NONE  = 2'b00;
    localparam logic [1:0] EVT_RXACT = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD_ACK, S_TX_DATA, S_REGW_DATA, S_REGW_STP, S_REGR_TURN, S_REGR_DATA,
        S_RX_TURN, S_RX_DATA, S_RX_END, S_RXCMD_TURN, S_DROP, S_TURN_OUT
    } state_t;

    // RX CMD byte: [7:6]=0, [5:4] rx event, [3:2] vbus, [1:0] linestate
    function automatic logic [7:0] rxcmd(input logic [1:0] evt, input logic [1:0] vbus,
                                         input logic [1:0] ls);
        return {2'b00, evt, vbus, ls};
    endfunction

    // op 0 = write, 1 = set, 2 = clear
    function automatic logic [7:0] reg_upd(input logic [7:0] cur, input logic [1:0] op,
                                           input logic [7:0] d);
        return (op == 2'd0) ? d : (op == 2'd1) ? (cur | d) : (cur & ~d);
    endfunction

    function automatic logic in_grp(input logic [5:0] a, input logic [5:0] base);
        return (a >= base) && (a <= base + 6'd2);
    endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// ulpi_phy_regfile: PHY register file with write/set/clear groups, read mux and
// self-clearing FUNC_CTRL reset bit that produces a one-cycle phy_reset pulse.
module ulpi_phy_regfile
    import ulpi_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [5:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] func_o,
    output logic [7:0] ifc_o,
    output logic [7:0] otg_o,
    output logic       phy_reset_o
);

    logic [7:0] func_q, func_d, ifc_q, ifc_d, otg_q, otg_d, func_n;
    logic       phy_reset_q, phy_reset_d, hit_f;

    always_comb begin
        func_n      = reg_upd(func_q, 2'(addr - A_FUNC), wdata);
        hit_f       = we && in_grp(addr, A_FUNC);
        func_d      = hit_f ? (func_n & ~(8'd1 << FUNC_RESET_BIT)) : func_q;
        phy_reset_d = hit_f && func_n[FUNC_RESET_BIT];
        ifc_d       = (we && in_grp(addr, A_IFC)) ? reg_upd(ifc_q, 2'(addr - A_IFC), wdata) : ifc_q;
        otg_d       = (we && in_grp(addr, A_OTG)) ? reg_upd(otg_q, 2'(addr - A_OTG), wdata) : otg_q;
        rdata       = 8'h00;
        case (addr)
            A_VID:         rdata = VENDOR_ID[7:0];
            A_VID + 6'd1:  rdata = VENDOR_ID[15:8];
            A_PID:         rdata = PRODUCT_ID[7:0];
            A_PID + 6'd1:  rdata = PRODUCT_ID[15:8];
            default: begin
                if (in_grp(addr, A_FUNC)) rdata = func_q;
                else if (in_grp(addr, A_IFC)) rdata = ifc_q;
                else if (in_grp(addr, A_OTG)) rdata = otg_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            func_q      <= FUNC_RST;
            ifc_q       <= IFC_RST;
            otg_q       <= OTG_RST;
            phy_reset_q <= 1'b0;
        end else begin
            func_q      <= func_d;
            ifc_q       <= ifc_d;
            otg_q       <= otg_d;
            phy_reset_q <= phy_reset_d;
        end
    end

    assign func_o      = func_q;
    assign ifc_o       = ifc_q;
    assign otg_o       = otg_q;
    assign phy_reset_o = phy_reset_q;

endmodule

// File: rtl/ulpi_phy_responder.sv
// ulpi_phy_responder: PHY-side ULPI responder handling link TX CMDs, register access,
// injected RX packets and linestate RX CMDs, all in the 60 MHz ULPI clock domain.
module ulpi_phy_responder
    import ulpi_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009,
    parameter logic [1:0]  VBUS_STATE = 2'b11
) (
    input  logic       ulpi_clk60_i,
    input  logic       ulpi_rst_i,
    input  logic [7:0] ulpi_data_i,
    input  logic       ulpi_stp_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_dir_o,
    output logic       ulpi_nxt_o,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_last_i,
    output logic       rx_ready_o,
    input  logic [1:0] linestate_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    output logic       tx_last_o,
    output logic [7:0] func_ctrl_o,
    output logic [7:0] ifc_ctrl_o,
    output logic [7:0] otg_ctrl_o,
    output logic       phy_reset_o
);

    state_t     state_q, state_d;
    logic       dir_q, dir_d, nxt_q, nxt_d, tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [7:0] data_q, data_d, tx_data_q, tx_data_d, cmd_q, cmd_d, hold_q, hold_d;
    logic [7:0] wdata_q, wdata_d, rdata;
    logic [1:0] last_ls_q, last_ls_d;
    logic       rx_take;

    assign rx_ready_o = (state_q == S_RX_TURN) || (state_q == S_RX_DATA);
    assign rx_take    = rx_valid_i && rx_ready_o;

    ulpi_phy_regfile #(.VENDOR_ID(VENDOR_ID), .PRODUCT_ID(PRODUCT_ID)) u_regs (
        .clk         (ulpi_clk60_i),
        .rst         (ulpi_rst_i),
        .we          ((state_q == S_REGW_STP) && ulpi_stp_i),
        .addr        (cmd_q[5:0]),
        .wdata       (wdata_q),
        .rdata       (rdata),
        .func_o      (func_ctrl_o),
        .ifc_o       (ifc_ctrl_o),
        .otg_o       (otg_ctrl_o),
        .phy_reset_o (phy_reset_o)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        nxt_d      = nxt_q;
        data_d     = data_q;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
        tx_data_d  = tx_data_q;
        cmd_d      = cmd_q;
        hold_d     = hold_q;
        wdata_d    = wdata_q;
        last_ls_d  = last_ls_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    dir_d   = 1'b1;
                    nxt_d   = 1'b1;
                    state_d = S_RX_TURN;
                end else if (ulpi_data_i[7:6] != 2'b00) begin
                    cmd_d   = ulpi_data_i;
                    nxt_d   = 1'b1;
                    state_d = S_CMD_ACK;
                end else if (ulpi_data_i == 8'h00 && linestate_i != last_ls_q) begin
                    dir_d   = 1'b1;
                    state_d = S_RXCMD_TURN;
                end
            end
            S_CMD_ACK: begin
                case (cmd_q[7:6])
                    CMD_TX: begin
                        hold_d  = {~cmd_q[3:0], cmd_q[3:0]};
                        state_d = S_TX_DATA;
                    end
                    CMD_REGW: state_d = S_REGW_DATA;
                    default: begin
                        nxt_d   = 1'b0;
                        dir_d   = 1'b1;
                        state_d = S_REGR_TURN;
                    end
                endcase
            end
            // each captured byte is released one cycle later, so STP can tag the final one
            S_TX_DATA: begin
                tx_valid_d = 1'b1;
                tx_data_d  = hold_q;
                tx_last_d  = ulpi_stp_i;
                hold_d     = ulpi_stp_i ? hold_q : ulpi_data_i;
                nxt_d      = !ulpi_stp_i;
                state_d    = ulpi_stp_i ? S_IDLE : S_TX_DATA;
            end
            S_REGW_DATA: begin
                wdata_d = ulpi_data_i;
                nxt_d   = 1'b0;
                state_d = S_REGW_STP;
            end
            S_REGW_STP:  state_d = S_IDLE;
            S_REGR_TURN: begin
                data_d  = rdata;
                state_d = S_REGR_DATA;
            end
            S_REGR_DATA: begin
                dir_d   = 1'b0;
                state_d = S_TURN_OUT;
            end
            S_RX_TURN, S_RX_DATA: begin
                nxt_d   = rx_take;
                data_d  = rx_take ? rx_data_i : rxcmd(EVT_RXACT, VBUS_STATE, linestate_i);
                state_d = (rx_take && rx_last_i) ? S_RX_END : S_RX_DATA;
            end
            S_RX_END, S_RXCMD_TURN: begin
                nxt_d     = 1'b0;
                data_d    = rxcmd(EVT_NONE, VBUS_STATE, linestate_i);
                last_ls_d = linestate_i;
                state_d   = S_DROP;
            end
            S_DROP: begin
                dir_d   = 1'b0;
                state_d = S_TURN_OUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ulpi_clk60_i or posedge ulpi_rst_i) begin
        if (ulpi_rst_i) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            nxt_q      <= 1'b0;
            data_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            cmd_q      <= 8'h00;
            hold_q     <= 8'h00;
            wdata_q    <= 8'h00;
            last_ls_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            nxt_q      <= nxt_d;
            data_q     <= data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_data_q  <= tx_data_d;
            cmd_q      <= cmd_d;
            hold_q     <= hold_d;
            wdata_q    <= wdata_d;
            last_ls_q  <= last_ls_d;
        end
    end

    assign ulpi_data_o = data_q;
    assign ulpi_dir_o  = dir_q;
    assign ulpi_nxt_o  = nxt_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign tx_last_o   = tx_last_q;

endmodule
